// File: rtl/pll_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer_if
//
// Bundles the lock input and the staged reset outputs of pll_reset_sequencer.
//
// Parameters:
//   CHANNELS    number of reset outputs (1..16)
//
// Signals:
//   pll_lock    raw asynchronous PLL lock flag (into the sequencer)
//   rst_out     per-domain active-high resets (from the sequencer)
//   ready       high when every rst_out bit is 0
//   seq_state   sequencer state encoding, for debug
//   loss_count  saturating lock-loss counter, present only when
//               RESET_SEQ_LOSS_COUNT_EN is defined
//
// Modports:
//   master      the sequencer side (drives resets, reads pll_lock)
//   slave       the PLL wrapper / consumer side
// -----------------------------------------------------------------------------
interface pll_reset_sequencer_if #(
  parameter int CHANNELS = 3
);
  logic                pll_lock;
  logic [CHANNELS-1:0] rst_out;
  logic                ready;
  logic [1:0]          seq_state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0]          loss_count;
`endif

  modport master (
    input  pll_lock,
    output rst_out,
    output ready,
    output seq_state
`ifdef RESET_SEQ_LOSS_COUNT_EN
    , output loss_count
`endif
  );

  modport slave (
    output pll_lock,
    input  rst_out,
    input  ready,
    input  seq_state
`ifdef RESET_SEQ_LOSS_COUNT_EN
    , input  loss_count
`endif
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Turns the asynchronous PLL lock flag into staged synchronous active-high
// resets for up to 16 domains clocked from the PLL output. Lock is
// synchronised, must stay high for STABLE_CYCLES, then channel resets are
// released one by one every STAGGER_CYCLES. Any loss of synchronised lock
// re-asserts every reset at once.
//
// Optional feature macro: RESET_SEQ_LOSS_COUNT_EN adds the saturating
// loss_count output and its register.
//
// Ports:
//   i_clock   PLL output clock, the only clock
//   i_reset   synchronous active-high reset, overrides everything
//   bus       pll_reset_sequencer_if.master:
//               pll_lock (in), rst_out/ready/seq_state[/loss_count] (out)
//
// States:
//   state      | meaning
//   WAIT_LOCK  | all resets asserted, waiting for synchronised lock
//   STABLE     | counting consecutive locked cycles
//   RELEASE    | releasing one channel every STAGGER_CYCLES
//   RUN        | all channels released, ready high
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int CHANNELS       = 3,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  pll_reset_sequencer_if.master bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(CHANNELS) + 1;

  localparam logic [CNT_W-1:0]    STABLE_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STAGGER_TC = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ALL_ON     = '1;
  localparam logic [CHANNELS-1:0] CH_ONE     = CHANNELS'(1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [CHANNELS-1:0]    r_rst_out;
  logic                   r_ready;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [7:0]             r_loss_count;
`endif

  logic w_lock_s;
  logic w_lost;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  // Any low cycle of the synchronised lock outside WAIT_LOCK is a full loss.
  assign w_lost   = (r_state != S_WAIT_LOCK) && !w_lock_s;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync     <= '0;
      r_state    <= S_WAIT_LOCK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rst_out  <= ALL_ON;
      r_ready    <= 1'b0;
`ifdef RESET_SEQ_LOSS_COUNT_EN
      r_loss_count <= '0;
`endif
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_lock};

      if (w_lost) begin
        r_state   <= S_WAIT_LOCK;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_rst_out <= ALL_ON;
        r_ready   <= 1'b0;
`ifdef RESET_SEQ_LOSS_COUNT_EN
        if (r_loss_count != 8'hFF) r_loss_count <= r_loss_count + 8'd1;
`endif
      end else begin
        case (r_state)
          S_WAIT_LOCK: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (w_lock_s) r_state <= S_STABLE;
          end

          S_STABLE: begin
            if (r_cnt == STABLE_TC) begin
              r_cnt        <= '0;
              r_rst_out[0] <= 1'b0;
              // A single channel has nothing to stagger: go straight to RUN.
              if (CHANNELS == 1) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
                r_idx   <= '0;
              end else begin
                r_state <= S_RELEASE;
                r_idx   <= IDX_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_RELEASE: begin
            if (r_cnt == STAGGER_TC) begin
              r_cnt     <= '0;
              r_rst_out <= r_rst_out & ~(CH_ONE << r_idx);
              r_idx     <= r_idx + IDX_W'(1);
              if (r_idx == LAST_IDX) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_RUN: begin
          end

          default: begin
            r_state <= S_WAIT_LOCK;
          end
        endcase
      end
    end
  end

  assign bus.rst_out   = r_rst_out;
  assign bus.ready     = r_ready;
  assign bus.seq_state = r_state;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  assign bus.loss_count = r_loss_count;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Two sequencers: u_dut0 with default parameters (3 channels, 1024 stable,
// 16 stagger) and u_dut1 with one channel and STABLE_CYCLES=4. Stimulus pushes
// the expected output changes (edge number, rst_out, ready, seq_state) into a
// queue per DUT; a monitor per DUT pops an entry each time the outputs change
// and compares. Loss counter checks are compiled in with
// RESET_SEQ_LOSS_COUNT_EN.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [1:0] st;
  } ev_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon0_en = 1'b0;
  bit   mon1_en = 1'b0;
  ev_t  q0[$];
  ev_t  q1[$];
  logic [5:0] prev0;
  logic [3:0] prev1;

  pll_reset_sequencer_if #(.CHANNELS(3)) bus0 ();
  pll_reset_sequencer_if #(.CHANNELS(1)) bus1 ();

  pll_reset_sequencer #(
    .CHANNELS(3), .STABLE_CYCLES(1024), .STAGGER_CYCLES(16), .SYNC_STAGES(2)
  ) u_dut0 (
    .i_clock(clk), .i_reset(rst0), .bus(bus0)
  );

  pll_reset_sequencer #(
    .CHANNELS(1), .STABLE_CYCLES(4), .STAGGER_CYCLES(16), .SYNC_STAGES(2)
  ) u_dut1 (
    .i_clock(clk), .i_reset(rst1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read on falling edges only.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push0(input int c, input logic [2:0] r, input logic d, input logic [1:0] s);
    q0.push_back('{cyc: c, rst: r, rdy: d, st: s});
  endtask

  task automatic push1(input int c, input logic r, input logic d, input logic [1:0] s);
    q1.push_back('{cyc: c, rst: {2'b00, r}, rdy: d, st: s});
  endtask

  // Full default sequence when pll_lock is first sampled high at edge b.
  task automatic push_seq0(input int b);
    push0(b + 2,    3'b111, 1'b0, 2'd1);
    push0(b + 1026, 3'b110, 1'b0, 2'd2);
    push0(b + 1042, 3'b100, 1'b0, 2'd2);
    push0(b + 1058, 3'b000, 1'b1, 2'd3);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_q(input bit which, input int limit, input string name);
    int n = 0;
    while ((which ? q1.size() : q0.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ((which ? q1.size() : q0.size()) != 0) begin
      bad++;
      $display("FAIL timeout_%s pending=%0d", name, which ? q1.size() : q0.size());
      if (which) q1.delete(); else q0.delete();
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t        e;
    cur = {bus0.seq_state, bus0.ready, bus0.rst_out};
    if (mon0_en) begin
      total++;
      if (bus0.ready !== (bus0.rst_out == 3'b000)) begin
        bad++;
        $display("FAIL ready_vs_rst0 cyc=%0d ready=%b rst_out=%b", cyc, bus0.ready, bus0.rst_out);
      end
      if (cur !== prev0) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL unexpected0 cyc=%0d st=%0d rdy=%b rst=%b",
                   cyc, bus0.seq_state, bus0.ready, bus0.rst_out);
        end else begin
          e = q0.pop_front();
          if (e.cyc != cyc || e.rst !== bus0.rst_out || e.rdy !== bus0.ready || e.st !== bus0.seq_state) begin
            bad++;
            $display("FAIL event0 got cyc=%0d st=%0d rdy=%b rst=%b exp cyc=%0d st=%0d rdy=%b rst=%b",
                     cyc, bus0.seq_state, bus0.ready, bus0.rst_out, e.cyc, e.st, e.rdy, e.rst);
          end
        end
      end
    end
    prev0 = cur;
  end

  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t        e;
    cur = {bus1.seq_state, bus1.ready, bus1.rst_out};
    if (mon1_en) begin
      total++;
      if (bus1.ready !== (bus1.rst_out == 1'b0)) begin
        bad++;
        $display("FAIL ready_vs_rst1 cyc=%0d ready=%b rst_out=%b", cyc, bus1.ready, bus1.rst_out);
      end
      if (cur !== prev1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL unexpected1 cyc=%0d st=%0d rdy=%b rst=%b",
                   cyc, bus1.seq_state, bus1.ready, bus1.rst_out);
        end else begin
          e = q1.pop_front();
          if (e.cyc != cyc || e.rst[0] !== bus1.rst_out[0] || e.rdy !== bus1.ready || e.st !== bus1.seq_state) begin
            bad++;
            $display("FAIL event1 got cyc=%0d st=%0d rdy=%b rst=%b exp cyc=%0d st=%0d rdy=%b rst=%b",
                     cyc, bus1.seq_state, bus1.ready, bus1.rst_out, e.cyc, e.st, e.rdy, e.rst[0]);
          end
        end
      end
    end
    prev1 = cur;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int e;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.pll_lock = 1'b0;
    bus1.pll_lock = 1'b0;
    repeat (4) @(negedge clk);

    check("reset_rst0", bus0.rst_out, 7);
    check("reset_rdy0", bus0.ready, 0);
    check("reset_st0", bus0.seq_state, 0);
    check("reset_rst1", bus1.rst_out, 1);
    check("reset_rdy1", bus1.ready, 0);
    check("reset_st1", bus1.seq_state, 0);
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("reset_loss0", bus0.loss_count, 0);
`endif
    mon0_en = 1'b1;
    mon1_en = 1'b1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (3) @(negedge clk);

    // Single channel, STABLE_CYCLES=4: release and ready together at edge 6.
    b = cyc + 1;
    push1(b + 2, 1'b1, 1'b0, 2'd1);
    push1(b + 6, 1'b0, 1'b1, 2'd3);
    bus1.pll_lock = 1'b1;
    wait_q(1'b1, 20, "single_channel");

    // Default sequence: 111 -> 110 @1026 -> 100 @1042 -> 000 + ready @1058.
    b = cyc + 1;
    push_seq0(b);
    bus0.pll_lock = 1'b1;
    wait_q(1'b0, 1100, "first_lock");
    repeat (5) @(negedge clk);

    // Loss in RUN: all resets back and WAIT_LOCK two edges after sampling.
    e = cyc + 1;
    push0(e + 2, 3'b111, 1'b0, 2'd0);
    bus0.pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    wait_q(1'b0, 4, "run_loss");
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("loss_after_run", bus0.loss_count, 1);
`endif

    // Relock, then a one-cycle drop around count 500 of STABLE.
    b = cyc + 1;
    push0(b + 2, 3'b111, 1'b0, 2'd1);
    bus0.pll_lock = 1'b1;
    repeat (502) @(negedge clk);
    e = cyc + 1;
    push0(e + 2, 3'b111, 1'b0, 2'd0);
    bus0.pll_lock = 1'b0;
    @(negedge clk);
    bus0.pll_lock = 1'b1;
    b = cyc + 1;
    push_seq0(b);
    wait_q(1'b0, 1100, "stable_drop");
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("loss_after_stable", bus0.loss_count, 2);
`endif

    // Glitch entirely between rising edges never reaches the synchroniser.
    repeat (3) @(negedge clk);
    #1 bus0.pll_lock = 1'b0;
    #1 bus0.pll_lock = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_rst", bus0.rst_out, 0);
    check("glitch_rdy", bus0.ready, 1);
    check("glitch_st", bus0.seq_state, 3);

    // Reset while in RELEASE with channel 0 already released.
    e = cyc + 1;
    push0(e + 2, 3'b111, 1'b0, 2'd0);
    bus0.pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    wait_q(1'b0, 4, "loss_before_reset");
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("loss_third", bus0.loss_count, 3);
`endif
    b = cyc + 1;
    push0(b + 2,    3'b111, 1'b0, 2'd1);
    push0(b + 1026, 3'b110, 1'b0, 2'd2);
    bus0.pll_lock = 1'b1;
    wait_q(1'b0, 1100, "partial_release");
    repeat (3) @(negedge clk);
    e = cyc + 1;
    push0(e, 3'b111, 1'b0, 2'd0);
    rst0 = 1'b1;
    repeat (2) @(negedge clk);
    wait_q(1'b0, 4, "reset_in_release");
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("loss_cleared", bus0.loss_count, 0);
`endif
    b = cyc + 1;
    push_seq0(b);
    rst0 = 1'b0;
    wait_q(1'b0, 1100, "after_reset");

`ifdef RESET_SEQ_LOSS_COUNT_EN
    // 300 forced losses on the single-channel instance: counter saturates.
    mon1_en = 1'b0;
    repeat (300) begin
      bus1.pll_lock = 1'b0;
      repeat (4) @(negedge clk);
      bus1.pll_lock = 1'b1;
      repeat (4) @(negedge clk);
    end
    check("loss_saturate", bus1.loss_count, 255);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Turns the raw, asynchronous PLL `LOCK` indication into a clean, staged set of synchronous active-high resets for up to 16 downstream domains clocked from the PLL output. It sits directly after the PLL wrapper and replaces the bare `reset = ~lock` assignment. It synchronises lock, requires lock to stay stable for a programmable time, releases channel resets one at a time with a fixed stagger, and re-asserts all of them on loss of lock.

## Interface
- `CHANNELS`, 3: number of reset outputs, legal range 1..16.
- `STABLE_CYCLES`, 1024: number of consecutive synchronised-lock cycles required before the first release. Must be ≥1.
- `STAGGER_CYCLES`, 16: cycles between successive channel releases. Must be ≥1.
- `SYNC_STAGES`, 2: flops in the lock synchroniser. Must be ≥2.

Ports:
- `clock` in 1: PLL output clock; the only clock in the block.
- `reset` in 1: synchronous, active-high; overrides everything.
- `pll_lock` in 1: asynchronous PLL lock flag.
- `rst_out` out CHANNELS: bit i is the active-high reset for domain i. All bits are registered.
- `ready` out 1: high exactly when all `rst_out` bits are 0.
- `seq_state` out 2: current state encoding, for debug.
- `loss_count` out 8: saturating count of lock-loss events. Present only when the configuration macro is defined.

## Operation
- Synchroniser: `pll_lock` passes through `SYNC_STAGES` flops. The last flop is `lock_s`. `reset` clears all synchroniser flops to 0.
- A single counter is shared between STABLE and RELEASE. Its width is `$clog2(max(STABLE_CYCLES,STAGGER_CYCLES))+1`. A channel index register is `$clog2(CHANNELS)+1` bits wide.
- WAIT_LOCK (0):
  - `rst_out` is all ones and `ready` is 0.
  - Counter is held at 0.
  - When `lock_s`=1, go to STABLE.
- STABLE (1):
  - Counter increments each cycle.
  - `lock_s`=0 returns to WAIT_LOCK and discards the count.
  - When the counter reaches `STABLE_CYCLES-1` with `lock_s`=1:
    - go to RELEASE,
    - clear `rst_out[0]` on the same edge,
    - set channel index to 1 and clear the counter.
- RELEASE (2):
  - Counter increments each cycle.
  - When it reaches `STAGGER_CYCLES-1`: clear `rst_out[index]`, increment the index, clear the counter.
  - When the last channel is cleared, go to RUN on the same edge and set `ready`=1.
  - With `CHANNELS`=1, STABLE goes straight to RUN: `rst_out[0]` clears and `ready` sets on the same edge.
- RUN (3):
  - Outputs are held.
  - `lock_s`=0 leads to WAIT_LOCK.
- Loss of lock:
  - Applies in STABLE, RELEASE and RUN.
  - When `lock_s` is 0 at an edge, the next state is WAIT_LOCK.
  - On that same edge `rst_out` becomes all ones and `ready` becomes 0. There is no partial release.
- Re-lock after a loss repeats the full STABLE and RELEASE sequence from channel 0.

## Timing
- Reset values: `rst_out` = all ones, `ready` = 0, `seq_state` = 0, `loss_count` = 0, counter and index = 0, synchroniser = 0.
- Reference timing: `pll_lock` is first sampled high at edge 0 and then stays high.
  - `lock_s` is high after edge `SYNC_STAGES-1`.
  - STABLE is entered at edge `SYNC_STAGES`.
  - `rst_out[0]` falls at edge `SYNC_STAGES+STABLE_CYCLES`. With defaults this is edge 1026.
  - `rst_out[i]` falls at edge `SYNC_STAGES+STABLE_CYCLES+i*STAGGER_CYCLES`.
  - `ready` rises with the last channel release. With defaults this is edge 1058.
- Loss latency: `pll_lock` is first sampled low at edge e.
  - `rst_out` is all ones and `ready` is 0 after edge `e+SYNC_STAGES`.
- A lock glitch that does not propagate to `lock_s` has no effect. Any `lock_s` low of one or more cycles is a full loss.
- `reset` asserted mid-sequence: on the next edge the block returns to WAIT_LOCK and all reset values are applied, regardless of `pll_lock`.
- `reset` and a lock-loss event in the same cycle: `reset` wins and `loss_count` does not increment.

## Configuration
- `RESET_SEQ_LOSS_COUNT_EN` defined:
  - The `loss_count` port and its register exist.
  - It increments by 1 on each STABLE/RELEASE/RUN to WAIT_LOCK transition caused by `lock_s`=0.
  - It saturates at 255 and is cleared only by `reset`.
- Not defined: the port and the register are absent. All other behaviour is identical.

## Test plan
- Defaults, `reset` for 4 cycles, then `pll_lock`=1 from edge 0:
  - `rst_out` goes 3'b111 → 3'b110 at edge 1026, → 3'b100 at edge 1042, → 3'b000 at edge 1058.
  - `ready` rises at edge 1058.
- `pll_lock` dropped for 1 cycle at count 500 in STABLE:
  - returns to WAIT_LOCK;
  - `rst_out[0]` releases `SYNC_STAGES+1024` edges after lock is sampled high again;
  - `loss_count`=1.
- `pll_lock` dropped while in RUN at edge e:
  - `rst_out`=3'b111 and `ready`=0 after edge e+2;
  - `seq_state`=0.
- `reset` asserted in RELEASE after channel 0 has been released:
  - next edge gives `rst_out`=3'b111 and `seq_state`=0;
  - full sequence restarts once `reset` is deasserted.
- `CHANNELS`=1, `STABLE_CYCLES`=4:
  - `rst_out[0]` and `ready` change on the same edge, edge 6.
- 300 forced lock losses with the macro defined:
  - `loss_count` saturates at 255.
  - Rebuild without the macro: the port is absent and the sequencing is unchanged.
